// File: rtl/result_serializer_pkg.sv
// rtl/result_serializer_pkg.sv - shared types and default sizing for the result serializer
package result_serializer_pkg;

    localparam int DEF_S2P_SIZE   = 3;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ACC_WIDTH  = 20;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        STREAM      = 2'd1,
        STREAM_PEND = 2'd2
    } ser_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/result_serializer_acc_saturate.sv
// rtl/result_serializer_acc_saturate.sv - arithmetic shift then clip of one accumulator word
module acc_saturate
    import result_serializer_pkg::*;
#(
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int SHIFT      = 0
) (
    input  logic [ACC_WIDTH-1:0]  acc,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  sat
);

    localparam logic signed [ACC_WIDTH-1:0] MAX_V = ACC_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] MIN_V = ~MAX_V;

    logic signed [ACC_WIDTH-1:0] shifted;

    always_comb begin
        shifted = $signed(acc) >>> SHIFT;
        data    = shifted[DATA_WIDTH-1:0];
        sat     = 1'b0;
        if (shifted > MAX_V) begin
            data = MAX_V[DATA_WIDTH-1:0];
            sat  = 1'b1;
        end else if (shifted < MIN_V) begin
            data = MIN_V[DATA_WIDTH-1:0];
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/result_serializer.sv
// rtl/result_serializer.sv - two-slot matrix parallel-to-serial requantizing streamer
module result_serializer
    import result_serializer_pkg::*;
#(
    parameter int S2P_SIZE   = DEF_S2P_SIZE,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int SHIFT      = 0
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [S2P_SIZE*S2P_SIZE*ACC_WIDTH-1:0] i_matrix_result,
    input  logic                                   i_valid,
    output logic                                   o_ready,
    output logic [DATA_WIDTH-1:0]                  o_data,
    output logic                                   o_valid,
    input  logic                                   i_ready,
    output logic                                   o_last,
    output logic                                   o_sat,
    output logic                                   o_drop,
    output logic                                   o_busy
);

    localparam int N     = S2P_SIZE * S2P_SIZE;
    localparam int IDX_W = idx_width(N);
    localparam int MAT_W = N * ACC_WIDTH;
    localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(N - 1);

    ser_state_t state, state_next;

    logic [MAT_W-1:0]      active_mat, pending_mat, src_mat;
    logic [IDX_W-1:0]      idx, idx_next;
    logic [ACC_WIDTH-1:0]  elem;
    logic [DATA_WIDTH-1:0] elem_data;
    logic                  elem_sat;
    logic accept, beat, final_beat, load_active, promote, present;

    assign o_ready     = (state != STREAM_PEND);
    assign o_busy      = (state != IDLE);
    assign accept      = i_valid & o_ready;
    assign beat        = o_valid & i_ready;
    assign final_beat  = beat & o_last;
    assign load_active = accept & ((state == IDLE) | final_beat);
    assign promote     = final_beat & (state == STREAM_PEND);
    assign present     = load_active | beat;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:        if (accept) state_next = STREAM;
            STREAM: begin
                if (final_beat)  state_next = accept ? STREAM : IDLE;
                else if (accept) state_next = STREAM_PEND;
            end
            STREAM_PEND: if (final_beat) state_next = STREAM;
            default:     state_next = IDLE;
        endcase
    end

    // The element for next cycle is selected from whichever matrix will be active then,
    // so a freshly loaded or promoted matrix presents its top slot without a bubble.
    always_comb begin
        src_mat  = active_mat;
        idx_next = idx;
        if (load_active) begin
            src_mat  = i_matrix_result;
            idx_next = FIRST_IDX;
        end else if (promote) begin
            src_mat  = pending_mat;
            idx_next = FIRST_IDX;
        end else if (beat && !o_last) begin
            idx_next = idx - 1'b1;
        end
    end

    always_comb begin
        elem = '0;
        for (int k = 0; k < N; k++) begin
            if (idx_next == IDX_W'(k)) elem = src_mat[k*ACC_WIDTH +: ACC_WIDTH];
        end
    end

    acc_saturate #(
        .ACC_WIDTH (ACC_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .SHIFT     (SHIFT)
    ) u_acc_saturate (
        .acc (elem),
        .data(elem_data),
        .sat (elem_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            active_mat  <= '0;
            pending_mat <= '0;
            o_valid     <= 1'b0;
            o_last      <= 1'b0;
            o_sat       <= 1'b0;
            o_data      <= '0;
            o_drop      <= 1'b0;
        end else begin
            state  <= state_next;
            o_drop <= i_valid & ~o_ready;
            if (load_active | promote) active_mat <= src_mat;
            if (accept & ~load_active) pending_mat <= i_matrix_result;
            if (present) begin
                idx <= idx_next;
                if (state_next == IDLE) begin
                    o_valid <= 1'b0;
                    o_data  <= '0;
                    o_last  <= 1'b0;
                    o_sat   <= 1'b0;
                end else begin
                    o_valid <= 1'b1;
                    o_data  <= elem_data;
                    o_sat   <= elem_sat;
                    o_last  <= (idx_next == '0);
                end
            end
        end
    end

endmodule
